// File: rtl/note_scheduler_pkg.sv
// Shared definitions for the rhythm-game note scheduler and the box renderer.
// Geometry defaults are shared so the renderer draws the same hit zone the judge uses.
package note_scheduler_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_OVER = 2'd2
  } game_state_t;

  localparam int unsigned LANES       = 4;
  localparam int unsigned DEF_BOX_H   = 50;
  localparam int unsigned DEF_HIT_TOP = 350;
  localparam int unsigned DEF_HIT_BOT = 400;
  localparam int unsigned SCORE_W     = 14;
  localparam int unsigned SCORE_MAX   = 9999;

  // Number of set bits in a four-lane event vector.
  function automatic logic [2:0] count4(input logic [3:0] v);
    count4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/note_scheduler_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with synchronous load and advance.
// Only the low two bits leave the block; they pick the spawn lane.
module note_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] low_bits
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

  assign low_bits = state[1:0];

endmodule

// File: rtl/note_scheduler.sv
// Game sequencer for the four-lane falling-box display: spawns and moves notes,
// judges presses against the hit zone, ramps speed and keeps score and game state.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int unsigned Y_W        = 11,
  parameter int unsigned BOX_H      = DEF_BOX_H,
  parameter int unsigned HIT_TOP    = DEF_HIT_TOP,
  parameter int unsigned HIT_BOT    = DEF_HIT_BOT,
  parameter int unsigned SPAWN_GAP  = 24,
  parameter int unsigned STEP_INIT  = 1,
  parameter int unsigned STEP_MAX   = 8,
  parameter int unsigned RAMP_HITS  = 16,
  parameter int unsigned MISS_LIMIT = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               frame_tick,
  input  logic [3:0]         btn_pulse,
  output logic [4*Y_W-1:0]   lane_y,
  output logic [3:0]         lane_active,
  output logic [3:0]         hit_pulse,
  output logic [3:0]         miss_pulse,
  output logic [13:0]        score,
  output logic [3:0]         misses,
  output logic [3:0]         step,
  output logic [1:0]         game_state
);

  localparam int unsigned CNT_W  = $clog2(SPAWN_GAP + 1);
  localparam int unsigned RAMP_W = $clog2(RAMP_HITS + LANES);
  localparam int unsigned YS_W   = Y_W + 1;

  game_state_t state_q, state_d;

  logic [LANES-1:0][Y_W-1:0] y_q, y_d;
  logic [3:0]                act_q, act_d;
  logic [3:0]                hit_q, hit_d;
  logic [3:0]                miss_q, miss_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic [3:0]                misses_q, misses_d;
  logic [3:0]                step_q, step_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [RAMP_W-1:0]         ramp_q, ramp_d;

  logic                      lfsr_load, lfsr_adv;
  logic [1:0]                spawn_lane;
  logic                      over_c;

  logic [YS_W-1:0]           ysum, ybot;
  logic [2:0]                n_hit, n_miss;
  logic [SCORE_W:0]          score_sum;
  logic [4:0]                miss_sum;
  logic [RAMP_W-1:0]         ramp_sum;

  note_lfsr #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .advance  (lfsr_adv),
    .low_bits (spawn_lane)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= GS_IDLE;
    else      state_q <= state_d;
  end

  // Start outranks everything; running out of misses ends the game.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = GS_PLAY;
    end else if (state_q == GS_PLAY && over_c) begin
      state_d = GS_OVER;
    end
  end

  always_comb begin
    y_d       = y_q;
    act_d     = act_q;
    hit_d     = '0;
    miss_d    = '0;
    score_d   = score_q;
    misses_d  = misses_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    ramp_d    = ramp_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    over_c    = 1'b0;
    ysum      = '0;
    ybot      = '0;
    n_hit     = '0;
    n_miss    = '0;
    score_sum = '0;
    miss_sum  = '0;
    ramp_sum  = '0;

    if (start) begin
      y_d       = '0;
      act_d     = '0;
      score_d   = '0;
      misses_d  = '0;
      ramp_d    = '0;
      step_d    = 4'(STEP_INIT);
      cnt_d     = CNT_W'(SPAWN_GAP);
      lfsr_load = 1'b1;
    end else if (state_q == GS_PLAY) begin
      // Presses are judged on the pre-tick position; a hit lane skips motion.
      for (int i = 0; i < LANES; i++) begin
        ybot = {1'b0, y_q[i]} + YS_W'(BOX_H);
        if (btn_pulse[i]) begin
          if (act_q[i] && ybot >= YS_W'(HIT_TOP) && {1'b0, y_q[i]} <= YS_W'(HIT_BOT)) begin
            hit_d[i] = 1'b1;
            act_d[i] = 1'b0;
            y_d[i]   = '0;
          end else begin
            miss_d[i] = 1'b1;
          end
        end
        if (frame_tick && act_d[i]) begin
          ysum = {1'b0, y_q[i]} + YS_W'(step_q);
          if (ysum > YS_W'(HIT_BOT)) begin
            act_d[i]  = 1'b0;
            y_d[i]    = '0;
            miss_d[i] = 1'b1;
          end else begin
            y_d[i] = ysum[Y_W-1:0];
          end
        end
      end

      if (frame_tick) begin
        lfsr_adv = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = CNT_W'(SPAWN_GAP);
          if (!act_d[spawn_lane]) begin
            act_d[spawn_lane] = 1'b1;
            y_d[spawn_lane]   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      n_hit  = count4(hit_d);
      n_miss = count4(miss_d);

      score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(n_hit);
      if (score_sum > (SCORE_W+1)'(SCORE_MAX)) score_d = SCORE_W'(SCORE_MAX);
      else                                     score_d = score_sum[SCORE_W-1:0];

      miss_sum = 5'(misses_q) + 5'(n_miss);
      if (miss_sum >= 5'(MISS_LIMIT)) begin
        misses_d = 4'(MISS_LIMIT);
        over_c   = 1'b1;
      end else begin
        misses_d = miss_sum[3:0];
      end

      // At most four hits per cycle, so the ramp counter wraps at most once.
      ramp_sum = ramp_q + RAMP_W'(n_hit);
      if (ramp_sum >= RAMP_W'(RAMP_HITS)) begin
        ramp_d = ramp_sum - RAMP_W'(RAMP_HITS);
        if (step_q < 4'(STEP_MAX)) step_d = step_q + 4'd1;
      end else begin
        ramp_d = ramp_sum;
      end

      if (over_c) begin
        act_d = '0;
        y_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q      <= '0;
      act_q    <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      score_q  <= '0;
      misses_q <= '0;
      step_q   <= '0;
      cnt_q    <= CNT_W'(SPAWN_GAP);
      ramp_q   <= '0;
    end else begin
      y_q      <= y_d;
      act_q    <= act_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      ramp_q   <= ramp_d;
    end
  end

  assign lane_y      = y_q;
  assign lane_active = act_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign step        = step_q;
  assign game_state  = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed game scenarios plus random play, all outputs
// compared every cycle against a lane-level behavioural model of the game rules.
module tb_note_scheduler;

  localparam int          YW   = 11;
  localparam logic [15:0] SEED = 16'hACE1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            frame_tick;
  logic [3:0]      btn_pulse;
  logic [4*YW-1:0] lane_y;
  logic [3:0]      lane_active;
  logic [3:0]      hit_pulse;
  logic [3:0]      miss_pulse;
  logic [13:0]     score;
  logic [3:0]      misses;
  logic [3:0]      step;
  logic [1:0]      game_state;

  note_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_tick  (frame_tick),
    .btn_pulse   (btn_pulse),
    .lane_y      (lane_y),
    .lane_active (lane_active),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .score       (score),
    .misses      (misses),
    .step        (step),
    .game_state  (game_state)
  );

  always #5 clk = ~clk;

  // Reference model: one integer position and one flag per lane.
  int         my [4];
  bit         ma [4];
  int         m_score, m_misses, m_step, m_ramp, m_ticks, m_state;
  logic [15:0] m_lfsr;
  logic [3:0] m_hit, m_miss;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) begin
      ma[i] = 1'b0;
      my[i] = 0;
    end
  endtask

  task automatic model_reset();
    clear_lanes();
    m_score = 0; m_misses = 0; m_step = 0; m_ramp = 0; m_ticks = 0; m_state = 0;
    m_lfsr = SEED; m_hit = '0; m_miss = '0;
  endtask

  task automatic model_step(input bit st, input bit tk, input logic [3:0] b);
    int nh, nm, l;
    m_hit = '0;
    m_miss = '0;
    if (st) begin
      clear_lanes();
      m_score = 0; m_misses = 0; m_ramp = 0; m_step = 1; m_ticks = 0;
      m_lfsr = SEED; m_state = 1;
      return;
    end
    if (m_state != 1) return;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        if (ma[i] && my[i] + 50 >= 350 && my[i] <= 400) begin
          m_hit[i] = 1'b1; ma[i] = 1'b0; my[i] = 0;
        end else begin
          m_miss[i] = 1'b1;
        end
      end
    end
    if (tk) begin
      for (int i = 0; i < 4; i++) begin
        if (ma[i]) begin
          my[i] += m_step;
          if (my[i] > 400) begin
            ma[i] = 1'b0; my[i] = 0; m_miss[i] = 1'b1;
          end
        end
      end
      m_ticks++;
      if (m_ticks == 24) begin
        m_ticks = 0;
        l = int'(m_lfsr[1:0]);
        if (!ma[l]) begin
          ma[l] = 1'b1; my[l] = 0;
        end
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    nh = $countones(m_hit);
    nm = $countones(m_miss);
    m_score  = (m_score + nh > 9999) ? 9999 : m_score + nh;
    m_misses = (m_misses + nm > 8) ? 8 : m_misses + nm;
    repeat (nh) begin
      m_ramp++;
      if (m_ramp == 16) begin
        m_ramp = 0;
        if (m_step < 8) m_step++;
      end
    end
    if (m_misses == 8) begin
      m_state = 2;
      clear_lanes();
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4*YW-1:0] ey;
    logic [3:0]      ea;
    ey = '0;
    ea = '0;
    for (int i = 0; i < 4; i++) begin
      ey[i*YW +: YW] = YW'(my[i]);
      ea[i] = ma[i];
    end
    chk("game_state", 64'(game_state), 64'(m_state));
    chk("lane_active", 64'(lane_active), 64'(ea));
    chk("lane_y", 64'(lane_y), 64'(ey));
    chk("hit_pulse", 64'(hit_pulse), 64'(m_hit));
    chk("miss_pulse", 64'(miss_pulse), 64'(m_miss));
    chk("score", 64'(score), 64'(m_score));
    chk("misses", 64'(misses), 64'(m_misses));
    chk("step", 64'(step), 64'(m_step));
  endtask

  task automatic cycle(input bit st, input bit tk, input logic [3:0] b);
    start = st; frame_tick = tk; btn_pulse = b;
    @(posedge clk);
    model_step(st, tk, b);
    #1;
    check_all();
    start = 1'b0; frame_tick = 1'b0; btn_pulse = '0;
  endtask

  function automatic int find_lane(input int target);
    for (int i = 0; i < 4; i++) if (ma[i] && my[i] == target) return i;
    return -1;
  endfunction

  function automatic logic [3:0] zone_mask();
    logic [3:0] z;
    z = '0;
    for (int i = 0; i < 4; i++) z[i] = ma[i] && my[i] >= 300 && my[i] <= 400;
    return z;
  endfunction

  function automatic int n_active();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (ma[i]) n++;
    return n;
  endfunction

  initial begin
    int         l, guard, sb, mb, el;
    bit         st, tk;
    logic [3:0] b;
    logic [15:0] x;

    rst = 1'b0; start = 1'b0; frame_tick = 1'b0; btn_pulse = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b1;

    // IDLE ignores ticks and presses
    repeat (3) cycle(1'b0, 1'b1, 4'hF);
    chk("idle_state", 64'(game_state), 64'(0));

    cycle(1'b1, 1'b0, 4'h0);
    chk("start_state", 64'(game_state), 64'(1));
    chk("start_step", 64'(step), 64'(1));

    repeat (23) cycle(1'b0, 1'b1, 4'h0);
    chk("pre_spawn", 64'(lane_active), 64'(0));
    cycle(1'b0, 1'b1, 4'h0);
    x = SEED;
    repeat (23) x = lfsr_next(x);
    el = int'(x[1:0]);
    chk("spawn_lane", 64'(lane_active), 64'(4'b0001 << el));
    chk("spawn_y", 64'(lane_y[el*YW +: YW]), 64'(0));

    // Hit at y=320
    guard = 0;
    while (find_lane(320) < 0 && guard < 2000) begin cycle(1'b0, 1'b1, 4'h0); guard++; end
    l = find_lane(320);
    chk("find_320", 64'(l >= 0), 64'(1));
    if (l >= 0) begin
      cycle(1'b0, 1'b0, 4'(4'b0001 << l));
      chk("hit320_pulse", 64'(hit_pulse[l]), 64'(1));
      chk("hit320_score", 64'(score), 64'(1));
      chk("hit320_clear", 64'(lane_active[l]), 64'(0));
    end

    // Early press at y=100 is a miss and the note keeps falling
    guard = 0;
    while (find_lane(100) < 0 && guard < 2000) begin cycle(1'b0, 1'b1, 4'h0); guard++; end
    l = find_lane(100);
    chk("find_100", 64'(l >= 0), 64'(1));
    if (l >= 0) begin
      mb = m_misses;
      cycle(1'b0, 1'b0, 4'(4'b0001 << l));
      chk("early_miss_pulse", 64'(miss_pulse[l]), 64'(1));
      chk("early_misses", 64'(misses), 64'(mb + 1));
      chk("early_active", 64'(lane_active[l]), 64'(1));
      chk("early_y", 64'(lane_y[l*YW +: YW]), 64'(100));
    end

    // Note at 400 passes on the next tick
    guard = 0;
    while (find_lane(400) < 0 && guard < 2000) begin cycle(1'b0, 1'b1, 4'h0); guard++; end
    l = find_lane(400);
    chk("find_400a", 64'(l >= 0), 64'(1));
    if (l >= 0) begin
      mb = m_misses;
      cycle(1'b0, 1'b1, 4'h0);
      chk("pass_miss_pulse", 64'(miss_pulse[l]), 64'(1));
      chk("pass_misses", 64'(misses), 64'(mb + 1));
    end

    // Press and tick together at 400 judge the pre-tick position
    guard = 0;
    while (find_lane(400) < 0 && guard < 2000) begin cycle(1'b0, 1'b1, 4'h0); guard++; end
    l = find_lane(400);
    chk("find_400b", 64'(l >= 0), 64'(1));
    if (l >= 0) begin
      sb = m_score;
      cycle(1'b0, 1'b1, 4'(4'b0001 << l));
      chk("edge_hit_pulse", 64'(hit_pulse[l]), 64'(1));
      chk("edge_no_miss", 64'(miss_pulse[l]), 64'(0));
      chk("edge_score", 64'(score), 64'(sb + 1));
    end

    // Auto-play for the speed ramp
    guard = 0;
    while (m_score < 16 && guard < 30000) begin cycle(1'b0, 1'b1, zone_mask()); guard++; end
    chk("ramp_step2", 64'(step), 64'(2));
    while (m_score < 112 && guard < 30000) begin cycle(1'b0, 1'b1, zone_mask()); guard++; end
    chk("ramp_step8", 64'(step), 64'(8));
    while (m_score < 130 && guard < 30000) begin cycle(1'b0, 1'b1, zone_mask()); guard++; end
    chk("ramp_hold8", 64'(step), 64'(8));
    chk("ramp_score", 64'(score >= 14'd130), 64'(1));

    // Run out of misses
    cycle(1'b0, 1'b0, zone_mask());
    sb = m_score;
    guard = 0;
    while (m_state == 1 && guard < 20) begin cycle(1'b0, 1'b0, 4'hF); guard++; end
    chk("over_state", 64'(game_state), 64'(2));
    chk("over_misses", 64'(misses), 64'(8));
    chk("over_score", 64'(score), 64'(sb));
    chk("over_lanes", 64'(lane_active), 64'(0));
    repeat (3) cycle(1'b0, 1'b1, 4'hF);
    chk("over_hold", 64'(score), 64'(sb));

    cycle(1'b1, 1'b1, 4'hF);
    chk("restart_state", 64'(game_state), 64'(1));
    chk("restart_score", 64'(score), 64'(0));
    chk("restart_misses", 64'(misses), 64'(0));
    chk("restart_step", 64'(step), 64'(1));

    // Asynchronous reset with several notes on screen
    guard = 0;
    while (n_active() < 3 && guard < 3000) begin cycle(1'b0, 1'b1, 4'h0); guard++; end
    chk("three_active", 64'(n_active() >= 3), 64'(1));
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (3) cycle(1'b0, 1'b1, 4'hF);
    chk("post_rst_state", 64'(game_state), 64'(0));

    // Random play
    repeat (4000) begin
      st = (m_state != 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 999) == 0);
      tk = $urandom_range(0, 1) == 1;
      b = '0;
      for (int i = 0; i < 4; i++) begin
        if (ma[i] && my[i] >= 300) b[i] = $urandom_range(0, 1) == 1;
        else                       b[i] = $urandom_range(0, 63) == 0;
      end
      cycle(st, tk, b);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
